// File: rtl/p4_router_ipv4_chksum_extern.sv
// rtl/p4_router_ipv4_chksum_extern.sv - IPv4 checksum verify/update user externs, fixed latency
// Optional statistics counters are built when P4_ROUTER_CHKSUM_STATS_EN is defined.
// Update operand layout in user_extern_out[191:160]: {hdr_chk[15:0], old_ttl[7:0], new_ttl[7:0]}.
module p4_router_ipv4_chksum_extern #(
  parameter int LATENCY    = 3,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [191:0]          user_extern_out,
  input  logic [1:0]            user_extern_out_valid,
  output logic [16:0]           user_extern_in,
  output logic [1:0]            user_extern_in_valid,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] stat_verify_cnt,
  output logic [STAT_WIDTH-1:0] stat_verify_err_cnt,
  output logic [STAT_WIDTH-1:0] stat_update_cnt
);

  // With LATENCY 2 stage 2 is combinational; otherwise the surplus cycles are plain delay registers.
  localparam int NDLY = (LATENCY == 2) ? 1 : LATENCY - 2;

  logic [15:0] hw [10];
  logic [18:0] psa_d, psb_d;
  logic        hok_d;
  logic [15:0] hc_n, m_n, m_p;
  logic [17:0] acc_d;

  // Stage 1 operands: header words (word 0 = version/ihl/tos), partial sums, update accumulator
  always_comb begin
    psa_d = '0;
    psb_d = '0;
    for (int i = 0; i < 10; i++) hw[i] = user_extern_out[159 - 16*i -: 16];
    for (int i = 0; i < 5; i++) begin
      psa_d = psa_d + 19'(hw[i]);
      psb_d = psb_d + 19'(hw[i+5]);
    end
    hok_d = (user_extern_out[159:152] == 8'h45);
    hc_n  = ~user_extern_out[191:176];
    m_n   = ~{user_extern_out[175:168], 8'h00};
    m_p   = {user_extern_out[167:160], 8'h00};
    acc_d = 18'(hc_n) + 18'(m_n) + 18'(m_p);
  end

  logic        s1_vv_q, s1_uv_q, s1_hok_q;
  logic [18:0] s1_psa_q, s1_psb_q;
  logic [17:0] s1_acc_q;

  // Stage 1 registers; data only loads on a valid request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vv_q  <= 1'b0;
      s1_uv_q  <= 1'b0;
      s1_hok_q <= 1'b0;
      s1_psa_q <= '0;
      s1_psb_q <= '0;
      s1_acc_q <= '0;
    end else begin
      s1_vv_q <= user_extern_out_valid[0];
      s1_uv_q <= user_extern_out_valid[1];
      if (user_extern_out_valid[0]) begin
        s1_psa_q <= psa_d;
        s1_psb_q <= psb_d;
        s1_hok_q <= hok_d;
      end
      if (user_extern_out_valid[1]) s1_acc_q <= acc_d;
    end
  end

  logic [19:0] vsum;
  logic [16:0] vf1, uf1;
  logic [15:0] vfold_d, ufold_d;

  // Stage 2 arithmetic: combine partial sums, two end-around carry folds on each path
  always_comb begin
    vsum    = 20'(s1_psa_q) + 20'(s1_psb_q);
    vf1     = 17'(vsum[15:0]) + 17'(vsum[19:16]);
    vfold_d = vf1[15:0] + 16'(vf1[16]);
    uf1     = 17'(s1_acc_q[15:0]) + 17'(s1_acc_q[17:16]);
    ufold_d = uf1[15:0] + 16'(uf1[16]);
  end

  logic        s2_vv, s2_uv, s2_hok;
  logic [15:0] s2_vfold, s2_ufold;

  generate
    if (LATENCY == 2) begin : g_s2_bypass
      assign s2_vv    = s1_vv_q;
      assign s2_uv    = s1_uv_q;
      assign s2_hok   = s1_hok_q;
      assign s2_vfold = vfold_d;
      assign s2_ufold = ufold_d;
    end else begin : g_s2_reg
      logic        s2_vv_q, s2_uv_q, s2_hok_q;
      logic [15:0] s2_vfold_q, s2_ufold_q;
      // Stage 2 registers holding the folded sums
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vv_q    <= 1'b0;
          s2_uv_q    <= 1'b0;
          s2_hok_q   <= 1'b0;
          s2_vfold_q <= '0;
          s2_ufold_q <= '0;
        end else begin
          s2_vv_q <= s1_vv_q;
          s2_uv_q <= s1_uv_q;
          if (s1_vv_q) begin
            s2_vfold_q <= vfold_d;
            s2_hok_q   <= s1_hok_q;
          end
          if (s1_uv_q) s2_ufold_q <= ufold_d;
        end
      end
      assign s2_vv    = s2_vv_q;
      assign s2_uv    = s2_uv_q;
      assign s2_hok   = s2_hok_q;
      assign s2_vfold = s2_vfold_q;
      assign s2_ufold = s2_ufold_q;
    end
  endgenerate

  // Final stage: packed {valid[1:0], updated checksum, verify bit}, fields zeroed when not valid
  logic [18:0] res_d;
  assign res_d = {s2_uv, s2_vv,
                  s2_uv ? ~s2_ufold : 16'h0000,
                  s2_vv & s2_hok & (s2_vfold == 16'hFFFF)};

  logic [18:0] dly_q [NDLY];

  // Final stage register followed by pure delay registers up to LATENCY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDLY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= res_d;
      for (int i = 1; i < NDLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign user_extern_in_valid = dly_q[NDLY-1][18:17];
  assign user_extern_in       = dly_q[NDLY-1][16:0];

`ifdef P4_ROUTER_CHKSUM_STATS_EN
  logic [STAT_WIDTH-1:0] ver_cnt_q, err_cnt_q, upd_cnt_q;
  logic                  err_inc;
  assign err_inc = user_extern_in_valid[0] & ~user_extern_in[0];

  // Saturating request/error counters; clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ver_cnt_q <= '0;
      err_cnt_q <= '0;
      upd_cnt_q <= '0;
    end else if (stat_clear) begin
      ver_cnt_q <= '0;
      err_cnt_q <= '0;
      upd_cnt_q <= '0;
    end else begin
      if (user_extern_out_valid[0] && (ver_cnt_q != '1)) ver_cnt_q <= ver_cnt_q + 1'b1;
      if (err_inc && (err_cnt_q != '1))                  err_cnt_q <= err_cnt_q + 1'b1;
      if (user_extern_out_valid[1] && (upd_cnt_q != '1)) upd_cnt_q <= upd_cnt_q + 1'b1;
    end
  end

  assign stat_verify_cnt     = ver_cnt_q;
  assign stat_verify_err_cnt = err_cnt_q;
  assign stat_update_cnt     = upd_cnt_q;
`else
  logic unused_stat_clear;
  assign unused_stat_clear   = stat_clear;
  assign stat_verify_cnt     = '0;
  assign stat_verify_err_cnt = '0;
  assign stat_update_cnt     = '0;
`endif

endmodule

// File: tb/tb_p4_router_ipv4_chksum_extern.sv
// tb/tb_p4_router_ipv4_chksum_extern.sv - self-checking bench for p4_router_ipv4_chksum_extern
module tb_p4_router_ipv4_chksum_extern;

  localparam int LAT = 3;
  localparam int SW  = 4;
  localparam int NC  = 4096;
  localparam logic [159:0] H1 = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [191:0]  ueo;
  logic [1:0]    ueov;
  logic [16:0]   uei;
  logic [1:0]    ueiv;
  logic          stat_clear;
  logic [SW-1:0] svc, svec, suc;

  always #5 clk = ~clk;

  p4_router_ipv4_chksum_extern #(.LATENCY(LAT), .STAT_WIDTH(SW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .user_extern_out       (ueo),
    .user_extern_out_valid (ueov),
    .user_extern_in        (uei),
    .user_extern_in_valid  (ueiv),
    .stat_clear            (stat_clear),
    .stat_verify_cnt       (svc),
    .stat_verify_err_cnt   (svec),
    .stat_update_cnt       (suc)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 0;
  int n_ver, n_err, n_upd;

  logic [1:0]  exp_vld [NC];
  logic [16:0] exp_dat [NC];

  always @(posedge clk) cyc <= cyc + 1;

  // One's-complement sum of the ten header words, fully folded
  function automatic logic [15:0] ones_sum(input logic [159:0] h);
    int s;
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(h[i*16 +: 16]);
    while (s > 65535) s = (s & 65535) + (s >> 16);
    return 16'(s);
  endfunction

  function automatic logic ref_verify(input logic [159:0] h);
    return (ones_sum(h) == 16'hFFFF) && (h[159:156] == 4'd4) && (h[155:152] == 4'd5);
  endfunction

  // HC' = ~(~HC + ~m + m') in one's-complement arithmetic
  function automatic logic [15:0] ref_update(input logic [15:0] hc, input logic [7:0] ot, input logic [7:0] nt);
    int s;
    s = (65535 - int'(hc)) + (65535 - int'({ot, 8'h00})) + int'({nt, 8'h00});
    while (s > 65535) s = (s & 65535) + (s >> 16);
    return 16'(65535 - s);
  endfunction

  function automatic logic [SW-1:0] sat(input int n);
    return (n >= (1 << SW) - 1) ? {SW{1'b1}} : SW'(n);
  endfunction

  // Output monitor: every cycle the full result bus must equal the scheduled expectation
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (ueiv !== exp_vld[cyc % NC] || uei !== exp_dat[cyc % NC]) begin
        failures++;
        $display("FAIL result cyc=%0d actual vld=%b dat=%h required vld=%b dat=%h",
                 cyc, ueiv, uei, exp_vld[cyc % NC], exp_dat[cyc % NC]);
      end
    end
  end

  task automatic drive_exp(input logic [1:0] v, input logic [191:0] d, input logic clr,
                           input logic ev, input logic [15:0] eu);
    int t;
    @(posedge clk);
    #1;
    ueo        = d;
    ueov       = v;
    stat_clear = clr;
    t = (cyc + LAT) % NC;
    if (clr) begin
      n_ver = 0;
      n_err = 0;
      n_upd = 0;
    end
    if (v[0]) begin
      exp_vld[t][0] = 1'b1;
      exp_dat[t][0] = ev;
      if (!clr) n_ver++;
      if (!ev) n_err++;
    end
    if (v[1]) begin
      exp_vld[t][1]    = 1'b1;
      exp_dat[t][16:1] = eu;
      if (!clr) n_upd++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_exp(2'b00, '0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    ueo        = '0;
    ueov       = 2'b00;
    stat_clear = 1'b0;
    for (int i = 0; i < NC; i++) begin
      exp_vld[i] = '0;
      exp_dat[i] = '0;
    end
    n_ver = 0;
    n_err = 0;
    n_upd = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_stats(input string nm);
    logic [SW-1:0] ev, ee, eu;
`ifdef P4_ROUTER_CHKSUM_STATS_EN
    ev = sat(n_ver);
    ee = sat(n_err);
    eu = sat(n_upd);
`else
    ev = '0;
    ee = '0;
    eu = '0;
`endif
    @(negedge clk);
    checks += 3;
    if (svc !== ev) begin
      failures++;
      $display("FAIL %s verify_cnt actual=%0d required=%0d", nm, svc, ev);
    end
    if (svec !== ee) begin
      failures++;
      $display("FAIL %s verify_err_cnt actual=%0d required=%0d", nm, svec, ee);
    end
    if (suc !== eu) begin
      failures++;
      $display("FAIL %s update_cnt actual=%0d required=%0d", nm, suc, eu);
    end
  endtask

  typedef struct {
    logic [1:0]   vld;
    logic [191:0] data;
    logic         ev;
    logic [15:0]  eu;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] h;
    logic [191:0] d;
    int r;

    tbl[0] = '{2'b01, {32'h0, H1}, 1'b1, 16'h0000};
    tbl[1] = '{2'b01, {32'h0, 160'h4500_0073_0000_4000_4011_B862_C0A8_0001_C0A8_00C7}, 1'b0, 16'h0000};
    tbl[2] = '{2'b01, {32'h0, 160'h6500_0073_0000_4000_4011_9861_C0A8_0001_C0A8_00C7}, 1'b0, 16'h0000};
    tbl[3] = '{2'b01, {32'h0, 160'h4600_0073_0000_4000_4011_B761_C0A8_0001_C0A8_00C7}, 1'b0, 16'h0000};
    tbl[4] = '{2'b10, {32'hB861_403F, 160'h0}, 1'b0, 16'hB961};
    tbl[5] = '{2'b10, {32'h00FF_0100, 160'h0}, 1'b0, 16'h01FF};
    tbl[6] = '{2'b10, {32'h0000_2020, 160'h0}, 1'b0, 16'h0000};
    tbl[7] = '{2'b11, {32'hB861_403F, H1}, 1'b1, 16'hB961};
    tbl[8] = '{2'b00, {32'hFFFF_FFFF, H1}, 1'b0, 16'h0000};

    rst_n      = 1'b0;
    ueo        = '0;
    ueov       = 2'b00;
    stat_clear = 1'b0;
    for (int i = 0; i < NC; i++) begin
      exp_vld[i] = '0;
      exp_dat[i] = '0;
    end
    mon_en = 1'b1;
    do_reset();
    check_stats("reset");

    // Directed vectors, back to back
    for (int i = 0; i < 9; i++) drive_exp(tbl[i].vld, tbl[i].data, 1'b0, tbl[i].ev, tbl[i].eu);
    idle(LAT + 2);
    check_stats("table");

    // Random headers on both externs every cycle
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 5; k++) h[k*32 +: 32] = $urandom();
      r = int'($urandom_range(0, 3));
      if (r != 0) h[159:152] = 8'h45;
      if (r >= 2) begin
        h[79:64] = 16'h0000;
        h[79:64] = ~ones_sum(h);
      end
      d = {32'($urandom()), h};
      drive_exp(2'b11, d, 1'b0, ref_verify(h), ref_update(d[191:176], d[175:168], d[167:160]));
    end
    idle(LAT + 2);
    check_stats("random");

    // Reset with two requests in flight: they must never produce results
    drive_exp(2'b11, {32'hB861_403F, H1}, 1'b0, 1'b1, 16'hB961);
    drive_exp(2'b11, {32'h00FF_0100, H1}, 1'b0, 1'b1, 16'h01FF);
    do_reset();
    idle(8);
    check_stats("midreset");
    drive_exp(2'b11, {32'hB861_403F, H1}, 1'b0, 1'b1, 16'hB961);
    idle(LAT + 2);

    // Clear coincident with a failing verify request: the clear wins, the later error counts
    drive_exp(tbl[1].vld, tbl[1].data, 1'b1, tbl[1].ev, tbl[1].eu);
    idle(LAT + 2);
    check_stats("clear_vs_inc");

    // Push the error counter past its ceiling
    for (int i = 0; i < (1 << SW) + 5; i++) drive_exp(tbl[2].vld, tbl[2].data, 1'b0, tbl[2].ev, tbl[2].eu);
    idle(LAT + 2);
    check_stats("saturate");

    drive_exp(2'b00, '0, 1'b1, 1'b0, 16'h0);
    idle(2);
    check_stats("clear");

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
